// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver control path:
//   - fixed state encoding of the receiver FSM
//   - legal oversampling (prescale) ratios
//   - offset of the checker-enable point relative to the bit midpoint
// No ports; imported with `import uart_rx_pkg::*;`.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  // State encoding is fixed so that downstream debug/observability logic can
  // decode the raw state value without depending on the enum declaration.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_VALID  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    VALID  = ST_VALID
  } rx_state_t;

  // Legal oversampling ratios.
  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // The majority sampler votes on edges M-1, M, M+1 (M = prescale/2); its
  // result is registered, so checkers/deserializer are enabled at M+2.
  localparam int unsigned SAMPLE_OFS = 2;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm_if
// Signal bundle between the UART receiver control FSM and its surroundings.
//   master : the side that drives the line/config/checker flags and consumes
//            the counters and enables (receiver datapath, or a testbench)
//   slave  : the control FSM itself
// Signals:
//   rx_in, prescale, par_en          line and frame configuration
//   strt_glitch, par_err, stp_err    registered checker flags
//   edge_cnt, bit_cnt                oversample / bit position
//   data_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en
//                                    datapath enables
//   data_valid                       one-cycle frame-good pulse
// Optional (macro UART_RX_BREAK_DET_EN): rx_zero_data in, break_det out.
// -----------------------------------------------------------------------------
interface uart_rx_fsm_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);

  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  data_samp_en;
  logic                  strt_chk_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
`ifdef UART_RX_BREAK_DET_EN
  logic                  rx_zero_data;
  logic                  break_det;
`endif

  modport master (
    output rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
`ifdef UART_RX_BREAK_DET_EN
    output rx_zero_data,
    input  break_det,
`endif
    input  edge_cnt, bit_cnt, data_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid
  );

  modport slave (
    input  rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
`ifdef UART_RX_BREAK_DET_EN
    input  rx_zero_data,
    output break_det,
`endif
    output edge_cnt, bit_cnt, data_samp_en, strt_chk_en, deser_en,
           par_chk_en, stp_chk_en, data_valid
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_bit_counter
// Oversample (edge) counter and bit counter of the UART receiver.
//   clk, rst  clock, synchronous active-high reset
//   clr       force both counters to 0
//   load1     restart a frame whose start-bit edge 0 has already elapsed:
//             edge_cnt = 1, bit_cnt = 0
//   en        advance edge_cnt; on wrap (edge_cnt == last) go to 0 and
//             increment bit_cnt
//   last      final oversample index of a bit (prescale - 1)
//   edge_cnt  current oversample index within the bit
//   bit_cnt   current bit index within the frame
//   at_last   edge_cnt == last (combinational)
// Priority: rst > load1 > clr > en.
// -----------------------------------------------------------------------------
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load1,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] last,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  at_last
);

  assign at_last = (edge_cnt == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (load1) begin
      edge_cnt <= PRESCALE_W'(1);
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (at_last) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// Control FSM of the UART receiver. Detects the start of a frame, owns the
// oversample/bit counters, sequences the sampler, checker and deserializer
// enables, and pulses data_valid for one cycle when a frame ends cleanly.
//
// Parameters:
//   DATA_WIDTH  data bits per frame
//   PRESCALE_W  width of prescale/edge_cnt (legal prescale 8, 16, 32)
//   BIT_CNT_W   bit counter width, must hold DATA_WIDTH+2
// Ports:
//   clk   receiver oversampling clock
//   rst   synchronous active-high reset (wins over everything)
//   bus   uart_rx_fsm_if.slave: rx_in, prescale, par_en, strt_glitch,
//         par_err, stp_err in; edge_cnt, bit_cnt, data_samp_en, strt_chk_en,
//         deser_en, par_chk_en, stp_chk_en, data_valid out
// Optional feature, macro UART_RX_BREAK_DET_EN: adds rx_zero_data/break_det.
// A stop error on an all-zero byte pulses break_det and holds the FSM in IDLE
// until rx_in has been high for prescale consecutive cycles.
//
// All enables are registered: each is set one cycle ahead (edge M+1) so that
// it is high exactly while edge_cnt == M+2.
// -----------------------------------------------------------------------------
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_fsm_if.slave bus
);

  rx_state_t             state;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  frame_err;

  logic [PRESCALE_W-1:0] last;
  logic [PRESCALE_W-1:0] pre_pt;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  at_last;
  logic                  at_pre;
  logic                  last_data;
  logic                  run;
  logic                  frame_end;
  logic                  cnt_clr;
  logic                  cnt_load1;
  logic                  start_ok;

  logic                  data_samp_en;
  logic                  strt_chk_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;

`ifdef UART_RX_BREAK_DET_EN
  logic                  break_det;
  logic                  brk_hold;
  logic [PRESCALE_W-1:0] brk_cnt;
`endif

  // Bit timing derived from the prescale latched at frame start.
  assign last      = prescale_q - PRESCALE_W'(1);
  assign pre_pt    = (prescale_q >> 1) + PRESCALE_W'(SAMPLE_OFS - 1);
  assign at_pre    = (edge_cnt == pre_pt);
  assign last_data = (bit_cnt == BIT_CNT_W'(DATA_WIDTH));

  assign run = (state == START) || (state == DATA) ||
               (state == PARITY) || (state == STOP);

  // Frame ends at the last edge of STOP, or of START on a false start. The
  // counters are cleared in the same cycle so that IDLE/VALID see them at 0.
  assign frame_end = at_last &&
                     ((state == STOP) || ((state == START) && bus.strt_glitch));
  assign cnt_clr   = !run || frame_end;

  // In VALID the low line is already edge 0 of the next start bit, so the
  // next START resumes at edge 1 and back-to-back frames lose no cycle.
  assign cnt_load1 = (state == VALID) && !bus.rx_in;

`ifdef UART_RX_BREAK_DET_EN
  assign start_ok      = !brk_hold && !bus.rx_in;
  assign bus.break_det = break_det;
`else
  assign start_ok = !bus.rx_in;
`endif

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load1    (cnt_load1),
    .en       (run),
    .last     (last),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .at_last  (at_last)
  );

  assign bus.edge_cnt     = edge_cnt;
  assign bus.bit_cnt      = bit_cnt;
  assign bus.data_samp_en = data_samp_en;
  assign bus.strt_chk_en  = strt_chk_en;
  assign bus.deser_en     = deser_en;
  assign bus.par_chk_en   = par_chk_en;
  assign bus.stp_chk_en   = stp_chk_en;
  assign bus.data_valid   = data_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prescale_q   <= PRESCALE_W'(PRESCALE_16);
      par_en_q     <= 1'b0;
      frame_err    <= 1'b0;
      data_samp_en <= 1'b0;
      strt_chk_en  <= 1'b0;
      deser_en     <= 1'b0;
      par_chk_en   <= 1'b0;
      stp_chk_en   <= 1'b0;
      data_valid   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det    <= 1'b0;
      brk_hold     <= 1'b0;
      brk_cnt      <= '0;
`endif
    end else begin
      // Single-cycle pulses default low.
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det   <= 1'b0;
`endif

      case (state)
        IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
          // After a break, wait for a full bit time of idle-high line.
          if (brk_hold) begin
            if (!bus.rx_in) begin
              brk_cnt <= '0;
            end else if (brk_cnt == last) begin
              brk_hold <= 1'b0;
              brk_cnt  <= '0;
            end else begin
              brk_cnt <= brk_cnt + PRESCALE_W'(1);
            end
          end
`endif
          if (start_ok) begin
            state        <= START;
            prescale_q   <= bus.prescale;
            par_en_q     <= bus.par_en;
            frame_err    <= 1'b0;
            data_samp_en <= 1'b1;
          end
        end

        START: begin
          strt_chk_en <= at_pre;
          if (at_last) begin
            if (bus.strt_glitch) begin
              state        <= IDLE;
              data_samp_en <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          deser_en <= at_pre;
          if (at_last && last_data) begin
            state <= par_en_q ? PARITY : STOP;
          end
        end

        PARITY: begin
          par_chk_en <= at_pre;
          if (at_last) begin
            // Parity failure does not abort the frame; it only vetoes VALID.
            frame_err <= frame_err | bus.par_err;
            state     <= STOP;
          end
        end

        STOP: begin
          stp_chk_en <= at_pre;
          if (at_last) begin
            data_samp_en <= 1'b0;
            if (!bus.stp_err && !frame_err) begin
              state      <= VALID;
              data_valid <= 1'b1;
            end else begin
              state <= IDLE;
`ifdef UART_RX_BREAK_DET_EN
              if (bus.stp_err && bus.rx_zero_data) begin
                break_det <= 1'b1;
                brk_hold  <= 1'b1;
                brk_cnt   <= '0;
              end
`endif
            end
          end
        end

        VALID: begin
          if (!bus.rx_in) begin
            state        <= START;
            frame_err    <= 1'b0;
            data_samp_en <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state        <= IDLE;
          data_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
// Directed bench for uart_rx_fsm. Frames are driven with bench-side timing;
// the expected data_valid cycle of every good frame is queued when the frame
// starts and compared when the pulse appears. Enable pulses are checked for
// their edge position and counted per frame.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

  localparam int DATA_WIDTH = 8;
  localparam int PRESCALE_W = 6;
  localparam int BIT_CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;

  uart_rx_fsm_if #(.PRESCALE_W(PRESCALE_W), .BIT_CNT_W(BIT_CNT_W)) bus ();

  uart_rx_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int n_strt = 0, n_deser = 0, n_par = 0, n_stp = 0;
  int cur_p = 8;
  int last_dv = -1, prev_dv = -1;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {16'd0, bus.edge_cnt, bus.bit_cnt, bus.data_samp_en, bus.strt_chk_en,
            bus.deser_en, bus.par_chk_en, bus.stp_chk_en, bus.data_valid};
  endfunction

  // Advance one cycle; sample on the falling edge and run the monitor.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.data_valid === 1'b1) begin
      prev_dv = last_dv;
      last_dv = cyc;
      if (exp_q.size() == 0) check("dv_unexpected", 32'(bus.data_valid), 0);
      else check("dv_cycle", cyc, exp_q.pop_front());
    end
    if (bus.strt_chk_en === 1'b1) begin n_strt++;  check("strt_chk_edge",  bus.edge_cnt, cur_p/2 + 2); end
    if (bus.deser_en    === 1'b1) begin n_deser++; check("deser_edge",     bus.edge_cnt, cur_p/2 + 2); end
    if (bus.par_chk_en  === 1'b1) begin n_par++;   check("par_chk_edge",   bus.edge_cnt, cur_p/2 + 2); end
    if (bus.stp_chk_en  === 1'b1) begin n_stp++;   check("stp_chk_edge",   bus.edge_cnt, cur_p/2 + 2); end
  endtask

  // Drive one frame. Called in an IDLE cycle (from_valid=0) or in the VALID
  // cycle of the previous frame (from_valid=1). Returns in the last STOP cycle.
  task automatic send_frame(input logic [7:0] data, input int p, input bit par,
                            input bit from_valid, input bit inj_par_err, input bit expect_ok);
    int s, nbits, idx;
    cur_p        = p;
    bus.prescale = PRESCALE_W'(p);
    bus.par_en   = par;
    nbits = DATA_WIDTH + 2 + (par ? 1 : 0);
    s = from_valid ? cyc : cyc + 1;
    if (expect_ok) exp_q.push_back(s + nbits * p);
    bus.rx_in = 1'b0;
    while (cyc < s + nbits * p - 1) begin
      tick();
      // Configuration changes mid-frame must be ignored.
      if (cyc == s + 1) begin
        bus.prescale = 6'd32;
        bus.par_en   = !par;
      end
      if (inj_par_err && (cyc - s == (DATA_WIDTH + 1) * p + p - 1)) bus.par_err = 1'b1;
      idx = (cyc + 1 - s) / p;
      if (idx == 0)                          bus.rx_in = 1'b0;
      else if (idx <= DATA_WIDTH)            bus.rx_in = data[idx-1];
      else if (par && idx == DATA_WIDTH + 1) bus.rx_in = ^data;
      else                                   bus.rx_in = 1'b1;
    end
    bus.rx_in = 1'b1;
  endtask

  initial begin
    int b_strt, b_deser, b_par, b_stp, t0, s;
    rst             = 1'b1;
    bus.rx_in       = 1'b1;
    bus.prescale    = 6'd8;
    bus.par_en      = 1'b1;
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    bus.rx_zero_data = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    check("reset_outputs", outs_vec(), 0);
    rst = 1'b0;
    repeat (4) tick();
    check("idle_after_reset", outs_vec(), 0);

    // Frame 0xA5, prescale 8, even parity, no errors
    b_strt = n_strt; b_deser = n_deser; b_par = n_par; b_stp = n_stp;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("a5_queue_empty", exp_q.size(), 0);
    check("a5_strt_cnt",  n_strt  - b_strt,  1);
    check("a5_deser_cnt", n_deser - b_deser, DATA_WIDTH);
    check("a5_par_cnt",   n_par   - b_par,   1);
    check("a5_stp_cnt",   n_stp   - b_stp,   1);
    repeat (3) tick();
    check("a5_idle_after", outs_vec(), 0);

    // Frame 0x3C, prescale 16, no parity
    b_deser = n_deser; b_par = n_par; b_stp = n_stp;
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("p16_queue_empty", exp_q.size(), 0);
    check("p16_deser_cnt", n_deser - b_deser, DATA_WIDTH);
    check("p16_par_cnt",   n_par   - b_par,   0);
    check("p16_stp_cnt",   n_stp   - b_stp,   1);
    repeat (3) tick();

    // False start: rx low 3 cycles, glitch flag at START edge 7
    cur_p = 8; bus.prescale = 6'd8; bus.par_en = 1'b1;
    b_strt = n_strt; b_deser = n_deser;
    t0 = cyc;
    bus.rx_in = 1'b0;
    repeat (3) tick();
    bus.rx_in = 1'b1;
    while (cyc < t0 + 8) tick();
    bus.strt_glitch = 1'b1;
    tick();
    bus.strt_glitch = 1'b0;
    check("false_start_idle", outs_vec(), 0);
    repeat (20) tick();
    check("false_start_strt_cnt",  n_strt  - b_strt,  1);
    check("false_start_deser_cnt", n_deser - b_deser, 0);
    check("false_start_queue", exp_q.size(), 0);

    // Parity error: frame runs through STOP, no data_valid
    b_par = n_par; b_stp = n_stp;
    send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    bus.par_err = 1'b0;
    check("par_err_par_cnt", n_par - b_par, 1);
    check("par_err_stp_cnt", n_stp - b_stp, 1);
    repeat (3) tick();
    check("par_err_idle", outs_vec(), 0);
    send_frame(8'h55, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("after_par_err_queue", exp_q.size(), 0);
    repeat (3) tick();

    // Back-to-back frames, second start bit low during VALID
    send_frame(8'h12, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    send_frame(8'h34, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_spacing", last_dv - prev_dv, 88);
    repeat (3) tick();

    // Reset at edge 3 of data bit 4
    cur_p = 8; bus.prescale = 6'd8; bus.par_en = 1'b1;
    s = cyc + 1;
    bus.rx_in = 1'b0;
    while (cyc < s + 4 * 8 + 3) begin
      tick();
      if (cyc >= s + 6) bus.rx_in = 1'b1;
    end
    check("pre_rst_edge", bus.edge_cnt, 3);
    check("pre_rst_bit",  bus.bit_cnt,  4);
    rst = 1'b1;
    tick();
    check("rst_midframe_outputs", outs_vec(), 0);
    rst = 1'b0;
    repeat (120) tick();
    check("rst_midframe_idle", outs_vec(), 0);
    send_frame(8'hC3, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("after_rst_queue", exp_q.size(), 0);

    repeat (5) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Control FSM of the UART receiver; sits directly downstream of the start-bit checker and consumes its glitch flag.
- Owns the edge (oversample) and bit counters.
- Detects frame start and sequences the data sampler, start/parity/stop checkers and deserializer enables.
- Issues a one-cycle data_valid when a frame completes without error.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of prescale input; legal prescale values 8, 16, 32.
- BIT_CNT_W, 4, bit counter width; must hold DATA_WIDTH+2.

Ports:
- clk  input  1  receiver oversampling clock
- rst  input  1  synchronous active-high reset
- rx_in  input  1  raw serial line, idle high
- prescale  input  PRESCALE_W  oversamples per bit; static while not IDLE
- par_en  input  1  parity bit present in frame
- strt_glitch  input  1  registered flag from start checker
- par_err  input  1  registered flag from parity checker
- stp_err  input  1  registered flag from stop checker
- edge_cnt  output  PRESCALE_W  current oversample index within bit
- bit_cnt  output  BIT_CNT_W  current bit index in frame (start = 0)
- data_samp_en  output  1  enable for 3-point majority sampler
- strt_chk_en  output  1  start checker enable
- deser_en  output  1  deserializer shift enable
- par_chk_en  output  1  parity checker enable
- stp_chk_en  output  1  stop checker enable
- data_valid  output  1  one-cycle frame-good pulse

Behaviour:
- Reset: all outputs 0, state IDLE. rst wins over every other input in the same cycle; reset mid-frame abandons the frame with no data_valid.
- States: IDLE, START, DATA, PARITY, STOP, VALID. Encoding is fixed by package constants.
- Let M = prescale/2 and L = prescale-1.
- edge_cnt:
  - Counts 0..L in every non-IDLE state except VALID.
  - Wraps to 0 after L.
  - bit_cnt increments on each wrap.
  - Both counters are held at 0 in IDLE and VALID.
- data_samp_en = 1 in START, DATA, PARITY and STOP. The sampler votes edges M-1, M, M+1.
- Enable pulses are one cycle each, asserted when edge_cnt == M+2:
  - strt_chk_en in START.
  - deser_en in DATA (once per data bit, DATA_WIDTH pulses total).
  - par_chk_en in PARITY.
  - stp_chk_en in STOP.
- IDLE -> START:
  - Taken on the cycle rx_in == 0 is seen.
  - edge_cnt = 0 in the following cycle.
- START at edge L:
  - strt_glitch == 1 -> IDLE (false start, no data_valid).
  - Otherwise -> DATA, bit_cnt = 1.
- DATA: after bit_cnt DATA_WIDTH wraps at edge L -> PARITY if par_en, else STOP.
- PARITY at edge L: -> STOP regardless of par_err; the error is carried into a registered frame_err.
- STOP at edge L:
  - -> VALID if !stp_err && !frame_err.
  - Otherwise -> IDLE.
- VALID:
  - data_valid = 1 for exactly one cycle, then IDLE.
  - If rx_in == 0 in VALID, go directly to START. Back-to-back frames lose no cycles.
- frame_err is cleared on entry to START.
- Latency: with par_en=1, data_valid is asserted (DATA_WIDTH+3)*prescale cycles after the first START cycle.
- rx_in toggling in DATA/PARITY/STOP does not affect state; only the checker flags and counters do.
- prescale and par_en are sampled only in IDLE (latched on IDLE->START). Mid-frame changes are ignored.

Optional Feature:
- Macro UART_RX_BREAK_DET_EN.
- When defined:
  - Adds input port rx_zero_data (1 = deserialized byte is all zero) and output port break_det.
  - break_det pulses one cycle at the STOP->IDLE transition when stp_err == 1 and rx_zero_data == 1.
  - break_det is 0 at reset.
  - The FSM then stays in IDLE until rx_in has been high for prescale consecutive cycles.
- When undefined:
  - Neither port exists.
  - Stop errors return to IDLE immediately.

Decomposition:
- Package uart_rx_pkg holds:
  - State encoding constants.
  - Legal prescale constants (8/16/32).
  - Sample-offset constant (M+2 check point).
- One natural sub-module: uart_rx_edge_bit_counter (edge_cnt/bit_cnt with enable and wrap), instantiated by the FSM.

Test Plan:
- prescale=8, par_en=1, even-parity frame 0xA5, no errors:
  - 8 deser_en pulses, one par_chk_en and one stp_chk_en, each at edge 6.
  - data_valid exactly 88 cycles after the first START cycle.
- prescale=16, par_en=0: 10-bit frame -> data_valid 160 cycles after START; par_chk_en never asserted.
- rx_in low for 3 cycles then high (prescale=8), strt_glitch=1 at edge 7 -> IDLE, no deser_en, data_valid stays 0.
- par_err=1 raised after par_chk_en -> FSM proceeds through STOP, returns to IDLE with no data_valid. A following good frame gives data_valid.
- Two frames back-to-back, second start bit low during VALID -> VALID->START directly, two data_valid pulses 88 cycles apart (prescale=8, par_en=1).
- rst asserted at edge 3 of data bit 4 -> next cycle all outputs 0, state IDLE. Subsequent frame decodes normally.
